split_slave_ctrl: RTL and testbench

Control FSM for the split-capable slave on the system bus. It accepts one read or write transaction at a time, issues it to the slave's backing store, and holds the bus while the store is fast. If the store is slow, it releases the bus with ssplit. When data returns it drops ssplit, waits for the arbiter's split_grant, and completes the response. It produces the sreadysp/ssplit pair the bus arbiter consumes and consumes that arbiter's split_grant.

---
 rtl/split_bus_pkg.sv | 23 ++
 rtl/split_lat_counter.sv | 34 +++
 rtl/split_slave_ctrl.sv | 151 +++++++++++++++
 tb/tb_split_slave_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/split_bus_pkg.sv
// rtl/split_bus_pkg.sv - shared split-bus types: slave FSM states, split owner codes, default widths
package split_bus_pkg;

    localparam int DEF_ADDR_W       = 12;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_SPLIT_THRESH = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        SPLIT  = 3'd2,
        RESUME = 3'd3,
        RESP   = 3'd4
    } slave_state_e;

    // Who currently owns the bus from the arbiter's point of view.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_MASTER = 2'd1,
        OWN_SPLIT  = 2'd2
    } split_owner_e;

endpackage

// File: rtl/split_lat_counter.sv
// rtl/split_lat_counter.sv - saturating store-latency counter with terminal count at THRESH-1
module split_lat_counter #(
    parameter int THRESH = 4,
    parameter int CW     = $clog2(THRESH + 1)
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(THRESH))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(THRESH - 1));

endmodule

// File: rtl/split_slave_ctrl.sv
// rtl/split_slave_ctrl.sv - split-capable slave control FSM; split path enabled by SPLIT_SLAVE_SPLIT_EN
module split_slave_ctrl
    import split_bus_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int SPLIT_THRESH = DEF_SPLIT_THRESH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mvalid,
    input  logic              mwrite,
    input  logic [ADDR_W-1:0] maddr,
    input  logic [DATA_W-1:0] mwdata,
    output logic              sready,
    output logic              ssplit,
    input  logic              split_grant,
    output logic              srvalid,
    output logic [DATA_W-1:0] srdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    slave_state_e      state_q, state_d;
    logic              ssplit_q, ssplit_d;
    logic              srvalid_q, srvalid_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] srdata_q, srdata_d;
    logic              cnt_clr, cnt_en;

`ifdef SPLIT_SLAVE_SPLIT_EN
    logic cnt_tc;

    split_lat_counter #(
        .THRESH (SPLIT_THRESH)
    ) u_lat_cnt (
        .clk_i  (clk),
        .rstn_i (rstn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    assign ssplit = ssplit_q;
`else
    logic unused_split;
    assign unused_split = ^{split_grant, cnt_clr, cnt_en, ssplit_q, (SPLIT_THRESH > 0)};
    assign ssplit       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ssplit_d    = ssplit_q;
        srvalid_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        srdata_d    = srdata_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mvalid) begin
                    mem_we_d    = mwrite;
                    mem_addr_d  = maddr;
                    mem_wdata_d = mwdata;
                    mem_req_d   = 1'b1;
                    cnt_clr     = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                cnt_en = 1'b1;
                // An ack on the threshold cycle takes priority over splitting.
                if (mem_ack) begin
                    srdata_d  = mem_rdata;
                    mem_req_d = 1'b0;
                    srvalid_d = 1'b1;
                    state_d   = RESP;
                end
`ifdef SPLIT_SLAVE_SPLIT_EN
                else if (cnt_tc) begin
                    ssplit_d = 1'b1;
                    state_d  = SPLIT;
                end
`endif
            end
`ifdef SPLIT_SLAVE_SPLIT_EN
            SPLIT: begin
                if (mem_ack) begin
                    srdata_d  = mem_rdata;
                    mem_req_d = 1'b0;
                    ssplit_d  = 1'b0;
                    state_d   = RESUME;
                end
            end
            RESUME: begin
                if (split_grant) begin
                    srvalid_d = 1'b1;
                    state_d   = RESP;
                end
            end
`endif
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ssplit_q    <= 1'b0;
            srvalid_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            srdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            ssplit_q    <= ssplit_d;
            srvalid_q   <= srvalid_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            srdata_q    <= srdata_d;
        end
    end

    assign sready    = (state_q == IDLE);
    assign srvalid   = srvalid_q;
    assign srdata    = srdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_split_slave_ctrl.sv
// tb/tb_split_slave_ctrl.sv - self-checking bench for split_slave_ctrl (SPLIT_SLAVE_SPLIT_EN optional)
module tb_split_slave_ctrl;

    localparam int AW     = 12;
    localparam int DW     = 8;
    localparam int THRESH = 4;
`ifdef SPLIT_SLAVE_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          mvalid = 1'b0;
    logic          mwrite = 1'b0;
    logic [AW-1:0] maddr = '0;
    logic [DW-1:0] mwdata = '0;
    logic          split_grant = 1'b0;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          sready, ssplit, srvalid, mem_req, mem_we;
    logic [DW-1:0] srdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    split_slave_ctrl #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .SPLIT_THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mvalid      (mvalid),
        .mwrite      (mwrite),
        .maddr       (maddr),
        .mwdata      (mwdata),
        .sready      (sready),
        .ssplit      (ssplit),
        .split_grant (split_grant),
        .srvalid     (srvalid),
        .srdata      (srdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: one outstanding access described by when it
    // started, when the store answered, and when the response is due.
    bit            m_busy = 1'b0;
    bit            m_acked = 1'b0;
    bit            m_split = 1'b0;
    int            m_start = 0;
    int            m_ack_cyc = 0;
    int            m_resp_cyc = -1;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("sready", 32'(sready), 32'(!m_busy));
                check("mem_req", 32'(mem_req), 32'(m_busy && !m_acked));
                check("ssplit", 32'(ssplit),
                      32'(SPLIT_EN && m_busy && !m_acked && (cyc - m_start >= THRESH)));
                check("srvalid", 32'(srvalid), 32'(m_busy && (m_resp_cyc == cyc)));
                check("mem_we", 32'(mem_we), 32'(m_we));
                check("mem_addr", 32'(mem_addr), 32'(m_addr));
                check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                if (m_busy && (m_resp_cyc == cyc) && !m_we)
                    check("srdata", 32'(srdata), 32'(m_rdata));
            end
            if (!rstn) begin
                m_busy = 1'b0; m_acked = 1'b0; m_resp_cyc = -1;
                m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else if (!m_busy) begin
                if (mvalid) begin
                    m_busy = 1'b1; m_acked = 1'b0; m_split = 1'b0;
                    m_start = cyc + 1; m_resp_cyc = -1;
                    m_we = mwrite; m_addr = maddr; m_wdata = mwdata;
                end
            end else begin
                if (!m_acked) begin
                    if (mem_ack) begin
                        m_acked = 1'b1; m_ack_cyc = cyc; m_rdata = mem_rdata;
                        m_split = SPLIT_EN && (cyc - m_start >= THRESH);
                        if (!m_split) m_resp_cyc = cyc + 1;
                    end
                end else if (m_split && (m_resp_cyc < 0) && (cyc > m_ack_cyc) && split_grant) begin
                    m_resp_cyc = cyc + 1;
                end
                if (m_resp_cyc == cyc) m_busy = 1'b0;
            end
        end
    end

    task automatic wait_idle(input string name);
        for (int k = 0; k < 20 && !sready; k++) step();
        check({name, " idle"}, 32'(sready), 32'd1);
    endtask

    // Offsets are cycles after mem_req rises; exp_lat is the hand-computed
    // distance from that first mem_req cycle to the srvalid cycle.
    task automatic run_txn(input string name, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int ack_at, input logic [DW-1:0] rd,
                           input int gnt_at, input int spur_mv, input int spur_gnt,
                           input int exp_lat);
        int lat;
        lat = -1;
        wait_idle(name);
        mvalid = 1'b1; mwrite = wr; maddr = a; mwdata = wd;
        step();
        mvalid = 1'b0;
        for (int k = 0; k < 60 && lat < 0; k++) begin
            mem_ack     = (k == ack_at);
            mem_rdata   = (k == ack_at) ? rd : 8'h00;
            split_grant = (k == gnt_at) || (k == spur_gnt);
            if (k == spur_mv) begin
                mvalid = 1'b1; mwrite = 1'b1; maddr = 12'h020; mwdata = 8'h55;
            end
            step();
            mem_ack = 1'b0; split_grant = 1'b0; mvalid = 1'b0;
            if (srvalid) lat = k + 1;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        if (!wr) check({name, " srdata"}, 32'(srdata), 32'(rd));
    endtask

    initial begin
        step();
        chk_en = 1'b1;
        step();
        rstn = 1'b1;
        step();
        check("reset sready", 32'(sready), 32'd1);
        check("reset ssplit", 32'(ssplit), 32'd0);
        check("reset srvalid", 32'(srvalid), 32'd0);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset srdata", 32'(srdata), 32'd0);

        run_txn("fast_rd", 1'b0, 12'h010, 8'h00, 2, 8'hA5, -1, -1, -1, 3);
        run_txn("boundary_rd", 1'b0, 12'h011, 8'h00, THRESH - 1, 8'h5A, -1, -1, -1, 4);
        run_txn("zero_wait_rd", 1'b0, 12'h012, 8'h00, 0, 8'hC3, -1, -1, -1, 1);
        run_txn("write", 1'b1, 12'h0AB, 8'h99, 1, 8'h00, -1, -1, -1, 2);
`ifdef SPLIT_SLAVE_SPLIT_EN
        run_txn("split_rd", 1'b0, 12'h013, 8'h00, 10, 8'h3C, 14, -1, -1, 15);
        run_txn("busy_ignore", 1'b0, 12'h014, 8'h00, 8, 8'h81, 10, 1, 5, 11);
`else
        run_txn("busy_ignore", 1'b0, 12'h014, 8'h00, 3, 8'h81, -1, 1, 2, 4);
        run_txn("late_ack", 1'b0, 12'h015, 8'h00, 20, 8'hE7, -1, -1, -1, 21);
`endif

        wait_idle("mid_reset");
        mvalid = 1'b1; mwrite = 1'b0; maddr = 12'h030;
        step();
        mvalid = 1'b0;
`ifdef SPLIT_SLAVE_SPLIT_EN
        for (int k = 0; k < 20 && !ssplit; k++) step();
        check("mid_reset split seen", 32'(ssplit), 32'd1);
`else
        step();
        step();
`endif
        rstn = 1'b0;
        step();
        check("mid_reset ssplit", 32'(ssplit), 32'd0);
        check("mid_reset mem_req", 32'(mem_req), 32'd0);
        check("mid_reset sready", 32'(sready), 32'd1);
        rstn = 1'b1;
        step();
        run_txn("post_reset_wr", 1'b1, 12'h001, 8'h77, 1, 8'h00, -1, -1, -1, 2);
        check("post_reset mem_addr", 32'(mem_addr), 32'h001);
        check("post_reset mem_wdata", 32'(mem_wdata), 32'h77);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
